// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM gate-drive path.
//
// Holds the one-hot state encoding of the dead-time driver FSM, the bit
// positions used to decode outputs straight from the state register, and
// the default parameter values. Benches for the upstream PWM generator can
// import the same package to decode the driver state.
package pwm_pkg;

    // Default parameter values for pwm_deadtime_driver.
    localparam int DT_W_DEF   = 8;
    localparam int MIN_ON_DEF = 4;
    localparam int ON_W_DEF   = 4;

    // Width of the one-hot state vector.
    localparam int ST_W = 6;

    // Bit positions inside the one-hot state vector.
    localparam int ST_IDLE_B     = 0;
    localparam int ST_DT_TO_HI_B = 1;
    localparam int ST_HI_ON_B    = 2;
    localparam int ST_DT_TO_LO_B = 3;
    localparam int ST_LO_ON_B    = 4;
    localparam int ST_FAULT_B    = 5;

    // One-hot state encoding. Each output is a single register bit, so no
    // decode glitch can ever assert both gate drives.
    typedef enum logic [ST_W-1:0] {
        ST_IDLE     = 6'b000001,
        ST_DT_TO_HI = 6'b000010,
        ST_HI_ON    = 6'b000100,
        ST_DT_TO_LO = 6'b001000,
        ST_LO_ON    = 6'b010000,
        ST_FAULT    = 6'b100000
    } pwm_state_e;

    // True for either dead-time state.
    function automatic logic is_dt_state(input pwm_state_e s);
        return (s == ST_DT_TO_HI) || (s == ST_DT_TO_LO);
    endfunction

    // True for either conducting state.
    function automatic logic is_on_state(input pwm_state_e s);
        return (s == ST_HI_ON) || (s == ST_LO_ON);
    endfunction

endpackage

// File: rtl/pwm_deadtime_driver_dt_counter.sv
// dt_counter: dead-time down-counter.
//
// Loads a start value, decrements by one per enabled cycle and reports when
// it has reached zero. The counter holds at zero rather than wrapping, so a
// stray decrement can never produce a long bogus dead time.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset (counter clears to 0)
//   load_i      load load_val_i this cycle (wins over dec_i)
//   dec_i       decrement this cycle
//   load_val_i  value to load
//   cnt_o       current count
//   zero_o      high when the count is zero
module dt_counter #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            dec_i,
    input  logic [DT_W-1:0] load_val_i,
    output logic [DT_W-1:0] cnt_o,
    output logic            zero_o
);

    logic [DT_W-1:0] cnt_q;
    logic [DT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pwm_deadtime_driver.sv
// pwm_deadtime_driver: complementary half-bridge gate drive with dead time.
//
// Takes the single-ended PWM command from the sine PWM generator and turns
// it into high-side / low-side gate drives. Every switch passes through a
// dead-time state in which both devices are off, and a conducting state is
// held for at least MIN_ON cycles before a switch request is honoured, so
// short command glitches are filtered out.
//
// Handshake/timing: there is no valid/ready flow here. pwm_in is a level
// that is registered once (pwm_s_q) and every decision uses that copy.
// fault_n is a synchronous level; fault_clr is a single-cycle strobe that
// only matters while the fault is latched.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   en             driver enable; low forces both outputs off
//   pwm_in         PWM command
//   dead_cycles    dead time in clk cycles (0 behaves as 1), sampled on
//                  entry to a dead-time state
//   fault_n        active-low external fault
//   fault_clr      request to leave the latched fault state
//   hs_out         high-side gate drive
//   ls_out         low-side gate drive
//   fault_latched  high while in FAULT
//   in_dt          high while in a dead-time state
//   dbg_state_o    raw one-hot state register, for observation
module pwm_deadtime_driver
    import pwm_pkg::*;
#(
    parameter int DT_W   = DT_W_DEF,
    parameter int MIN_ON = MIN_ON_DEF,  // >= 1; 1 disables filtering
    parameter int ON_W   = ON_W_DEF     // 2**ON_W must exceed MIN_ON
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_cycles,
    input  logic            fault_n,
    input  logic            fault_clr,
    output logic            hs_out,
    output logic            ls_out,
    output logic            fault_latched,
    output logic            in_dt,
    output logic [ST_W-1:0] dbg_state_o
);

    localparam logic [ON_W-1:0] MIN_ON_C    = ON_W'(MIN_ON);
    localparam logic [ON_W-1:0] MIN_ON_M1_C = ON_W'(MIN_ON - 1);

    pwm_state_e      state_q;
    pwm_state_e      state_d;
    logic            pwm_s_q;
    logic [ON_W-1:0] on_cnt_q;
    logic [ON_W-1:0] on_cnt_d;

    logic            dt_load;
    logic            dt_dec;
    logic [DT_W-1:0] dt_load_val;
    logic [DT_W-1:0] dt_cnt;
    logic            dt_zero;
    logic            on_ok;
    logic [ST_W-1:0] state_bits;

    // ------------------------------------------------------------------
    // Input register: the only copy of the command the FSM looks at.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_s_q <= 1'b0;
        end else begin
            pwm_s_q <= pwm_in;
        end
    end

    // ------------------------------------------------------------------
    // Dead-time timer. The loaded value is (dead time - 1) because the
    // entry cycle itself is the first dead-time cycle; 0 is clamped to 1.
    // ------------------------------------------------------------------
    assign dt_load_val = (dead_cycles == '0) ? '0 : (dead_cycles - DT_W'(1));
    assign dt_load     = is_dt_state(state_d) && !is_dt_state(state_q);
    assign dt_dec      = is_dt_state(state_q);

    dt_counter #(
        .DT_W (DT_W)
    ) u_dt_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (dt_load),
        .dec_i      (dt_dec),
        .load_val_i (dt_load_val),
        .cnt_o      (dt_cnt),
        .zero_o     (dt_zero)
    );

    // ------------------------------------------------------------------
    // Minimum on-time: the counter reads 0 in the first on-state cycle,
    // so a switch can first be taken in cycle MIN_ON of the on-state.
    // ------------------------------------------------------------------
    assign on_ok = (on_cnt_q >= MIN_ON_M1_C);

    always_comb begin
        on_cnt_d = on_cnt_q;
        if (is_on_state(state_d) && (state_d != state_q)) begin
            on_cnt_d = '0;
        end else if (is_on_state(state_q) && (on_cnt_q < MIN_ON_C)) begin
            on_cnt_d = on_cnt_q + ON_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_cnt_q <= '0;
        end else begin
            on_cnt_q <= on_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic. Priority: fault, then enable, then normal.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!fault_n) begin
            state_d = ST_FAULT;
        end else if (state_q == ST_FAULT) begin
            // Leave only on an explicit clear while the fault input is gone.
            if (fault_clr) begin
                state_d = ST_IDLE;
            end
        end else if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = pwm_s_q ? ST_DT_TO_HI : ST_DT_TO_LO;
                end
                // Exit follows the current command, not the state's name:
                // returning to the side that was just on is safe because
                // the opposite device never conducted.
                ST_DT_TO_HI, ST_DT_TO_LO: begin
                    if (dt_zero) begin
                        state_d = pwm_s_q ? ST_HI_ON : ST_LO_ON;
                    end
                end
                ST_HI_ON: begin
                    if (!pwm_s_q && on_ok) begin
                        state_d = ST_DT_TO_LO;
                    end
                end
                ST_LO_ON: begin
                    if (pwm_s_q && on_ok) begin
                        state_d = ST_DT_TO_HI;
                    end
                end
                // Any non-one-hot value recovers through IDLE (outputs off).
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: each is one bit of the state register, so they change
    // cleanly on the clock edge and drop with the asynchronous reset.
    // ------------------------------------------------------------------
    assign state_bits    = state_q;
    assign hs_out        = state_bits[ST_HI_ON_B];
    assign ls_out        = state_bits[ST_LO_ON_B];
    assign in_dt         = state_bits[ST_DT_TO_HI_B] | state_bits[ST_DT_TO_LO_B];
    assign fault_latched = state_bits[ST_FAULT_B];
    assign dbg_state_o   = state_bits;

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
`timescale 1ns/1ps
module tb_pwm_deadtime_driver;
  import pwm_pkg::*;

  localparam int DT_W = 8;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            en = 1'b0;
  logic            pwm_in = 1'b0;
  logic [DT_W-1:0] dead_cycles = 8'd10;
  logic            fault_n = 1'b1;
  logic            fault_clr = 1'b0;
  logic            hs_out;
  logic            ls_out;
  logic            fault_latched;
  logic            in_dt;
  logic [ST_W-1:0] dbg_state;

  always #5 clk = ~clk;

  pwm_deadtime_driver #(
    .DT_W   (DT_W),
    .MIN_ON (4),
    .ON_W   (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .pwm_in        (pwm_in),
    .dead_cycles   (dead_cycles),
    .fault_n       (fault_n),
    .fault_clr     (fault_clr),
    .hs_out        (hs_out),
    .ls_out        (ls_out),
    .fault_latched (fault_latched),
    .in_dt         (in_dt),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic overlap_seen = 1'b0;

  // Any instant with both drives on, clocked or not.
  always @(hs_out, ls_out) begin
    if (hs_out && ls_out) overlap_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic hs, input logic ls,
                            input logic dt, input logic flt);
    check({tag, ".hs"}, {31'd0, hs_out}, {31'd0, hs});
    check({tag, ".ls"}, {31'd0, ls_out}, {31'd0, ls});
    check({tag, ".dt"}, {31'd0, in_dt}, {31'd0, dt});
    check({tag, ".flt"}, {31'd0, fault_latched}, {31'd0, flt});
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Command edge from a settled on-state. Old side stays on for 1 sample,
  // falls at sample 2, new side rises at sample 2 + deff.
  task automatic pwm_edge(input logic val, input int deff, input int hold);
    logic old_on, new_on, dt;
    pwm_in = val;
    for (int s = 1; s <= 2 + deff; s++) begin
      step();
      old_on = (s < 2);
      new_on = (s >= 2 + deff);
      dt     = (s >= 2) && (s < 2 + deff);
      check_outs($sformatf("edge%0b_d%0d_s%0d", val, deff, s),
                 val ? new_on : old_on, val ? old_on : new_on, dt, 1'b0);
    end
    repeat (hold) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.state", {26'd0, dbg_state}, {26'd0, ST_IDLE});
    #8 rst_n = 1'b1;
    step();
    step();
    check_outs("idle_en0", 1'b0, 1'b0, 1'b0, 1'b0);

    // Nominal start-up: IDLE -> DT_TO_LO (10 cycles) -> LO_ON
    en = 1'b1;
    step();
    check_outs("start_dt_first", 1'b0, 1'b0, 1'b1, 1'b0);
    check("start.state", {26'd0, dbg_state}, {26'd0, ST_DT_TO_LO});
    repeat (9) step();
    check_outs("start_dt_last", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("start_lo_on", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) step();

    // Nominal 100-cycle square wave, dead time 10
    pwm_edge(1'b1, 10, 38);
    pwm_edge(1'b0, 10, 38);
    pwm_edge(1'b1, 10, 38);
    pwm_edge(1'b0, 10, 0);   // ends on the LO_ON entry cycle

    // Glitch filter: 2-cycle pulse right after entering LO_ON is ignored
    dead_cycles = 8'd2;
    pwm_in = 1'b1;
    step();
    step();
    pwm_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_outs($sformatf("glitch_%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // 6-cycle pulse is accepted; fall lands exactly when min-on allows it
    pwm_in = 1'b1;
    step();
    check_outs("pulse6_s1", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_outs("pulse6_s2", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("pulse6_s3", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("pulse6_s4", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_outs("pulse6_s6", 1'b1, 1'b0, 1'b0, 1'b0);
    pwm_edge(1'b0, 2, 8);

    // dead_cycles = 0 behaves as 1: opposite side rises 3 cycles later
    dead_cycles = 8'd0;
    pwm_edge(1'b1, 1, 8);
    pwm_edge(1'b0, 1, 8);

    // Reversal in dead time; mid-DT dead_cycles change has no effect
    dead_cycles = 8'd10;
    pwm_in = 1'b1;
    step();
    check_outs("rev_s1", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("rev.state", {26'd0, dbg_state}, {26'd0, ST_DT_TO_HI});
    pwm_in = 1'b0;
    for (int s = 3; s <= 11; s++) begin
      step();
      if (s == 4) dead_cycles = 8'd3;
      check_outs($sformatf("rev_s%0d", s), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    step();
    check_outs("rev_s12", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (8) step();

    // Fault during HI_ON (dead time 3)
    pwm_edge(1'b1, 3, 8);
    fault_clr = 1'b1;            // ignored outside FAULT
    step();
    fault_clr = 1'b0;
    check_outs("clr_outside_fault", 1'b1, 1'b0, 1'b0, 1'b0);
    fault_n = 1'b0;
    step();
    check_outs("fault_entry", 1'b0, 1'b0, 1'b0, 1'b1);
    check("fault.state", {26'd0, dbg_state}, {26'd0, ST_FAULT});
    fault_clr = 1'b1;            // fault still present: stay
    step();
    fault_clr = 1'b0;
    check_outs("fault_clr_blocked", 1'b0, 1'b0, 1'b0, 1'b1);
    fault_n = 1'b1;              // fault gone but no clear: stay
    step();
    check_outs("fault_no_clr", 1'b0, 1'b0, 1'b0, 1'b1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check_outs("fault_cleared", 1'b0, 1'b0, 1'b0, 1'b0);
    check("cleared.state", {26'd0, dbg_state}, {26'd0, ST_IDLE});
    step();
    check_outs("recover_dt1", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    check_outs("recover_dt3", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("recover_hi", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) step();

    // Enable drop during DT_TO_LO
    dead_cycles = 8'd10;
    pwm_in = 1'b0;
    step();
    step();
    check("en.state_dt", {26'd0, dbg_state}, {26'd0, ST_DT_TO_LO});
    step();
    en = 1'b0;
    step();
    check_outs("en_off", 1'b0, 1'b0, 1'b0, 1'b0);
    check("en_off.state", {26'd0, dbg_state}, {26'd0, ST_IDLE});
    step();
    check_outs("en_off_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    step();
    check_outs("en_on_dt", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (9) step();
    check_outs("en_on_dt_last", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("en_on_lo", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (8) step();

    // Asynchronous reset in HI_ON
    pwm_edge(1'b1, 10, 8);
    #2 rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("async_rst.state", {26'd0, dbg_state}, {26'd0, ST_IDLE});
    #1 rst_n = 1'b1;
    // pwm_s restarted at 0, so the first decision heads for DT_TO_LO,
    // then the DT exit follows the real command (high).
    step();
    check("post_rst.state", {26'd0, dbg_state}, {26'd0, ST_DT_TO_LO});
    repeat (9) step();
    check_outs("post_rst_dt_last", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("post_rst_hi", 1'b1, 1'b0, 1'b0, 1'b0);

    // Invariant over the whole run
    check("no_overlap", {31'd0, overlap_seen}, 32'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_driver.md
Name: pwm_deadtime_driver

Overview:
- Downstream stage of sine_pwm_simple. Consumes its single-ended pwm_out and produces complementary high-side and low-side gate drives for a half-bridge.
- Inserts programmable dead time and enforces a minimum on-time, so the two outputs are never asserted together.
- Runs in the same clock domain as the PWM generator. Feeds the FPGA gate-driver pins on the Zedboard.

Parameters:
- DT_W, 8, width of the dead-time configuration and dead-time counter.
- MIN_ON, 4, minimum cycles an on-state (HI_ON/LO_ON) is held before a switch is accepted; must be ≥1 (1 = no filtering).
- ON_W, 4, width of the on-time counter; must satisfy 2^ON_W > MIN_ON.

Ports:
- clk, in, 1, system clock (500 MHz nominal, same as sine_pwm_simple).
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, driver enable; low forces both outputs off.
- pwm_in, in, 1, PWM command from sine_pwm_simple.pwm_out.
- dead_cycles, in, DT_W, dead-time length in clk cycles; sampled on entry to a DT state; 0 is treated as 1.
- fault_n, in, 1, active-low external fault, sampled synchronously.
- fault_clr, in, 1, single-cycle request to clear a latched fault.
- hs_out, out, 1, high-side gate drive.
- ls_out, out, 1, low-side gate drive.
- fault_latched, out, 1, high while in FAULT.
- in_dt, out, 1, high while in DT_TO_HI or DT_TO_LO.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; hs_out=0, ls_out=0, fault_latched=0, in_dt=0; pwm_s=0; all counters 0.
- Input register: pwm_in is registered once into pwm_s; all decisions use pwm_s.
- Outputs: decoded from the one-hot state register (glitch-free):
  - hs_out = HI_ON
  - ls_out = LO_ON
  - in_dt = DT_TO_HI | DT_TO_LO
  - fault_latched = FAULT
- States: IDLE, DT_TO_HI, HI_ON, DT_TO_LO, LO_ON, FAULT.
- Transition priority per cycle: fault_n=0 > en=0 > normal.
  - fault_n=0 from any state → FAULT.
  - en=0 from any non-FAULT state → IDLE.
- IDLE, en=1: pwm_s=1 → DT_TO_HI; pwm_s=0 → DT_TO_LO.
- DT states:
  - On entry, dt_cnt loads max(dead_cycles,1)-1.
  - dt_cnt decrements each cycle; the state lasts exactly max(dead_cycles,1) cycles.
  - When dt_cnt==0, exit to HI_ON if pwm_s=1, else LO_ON, regardless of which DT state is active. Re-entering the prior side is allowed because the opposite device was never turned on.
  - A dead_cycles change mid-DT has no effect until the next DT entry.
- HI_ON / LO_ON:
  - on_cnt clears on entry and increments, saturating at MIN_ON.
  - HI_ON → DT_TO_LO when pwm_s=0 and on_cnt ≥ MIN_ON-1.
  - LO_ON → DT_TO_HI when pwm_s=1 and on_cnt ≥ MIN_ON-1.
  - Pulses on pwm_s shorter than the remaining min-on window are ignored.
- FAULT: both outputs off. Exit to IDLE only when fault_clr=1 and fault_n=1 in the same cycle; otherwise stay. fault_clr outside FAULT is ignored.
- Latency:
  - pwm_in edge to the falling output: 2 cycles.
  - pwm_in edge to the rising opposite output: 2 + max(dead_cycles,1) cycles.
- Invariant: hs_out & ls_out is never 1 in any cycle, including reset release and mid-DT enable/fault events.
- Reset mid-operation: outputs drop to 0 immediately (asynchronously) and the block restarts in IDLE.

Decomposition:
- Shared package pwm_pkg: state enum (one-hot encoding constants) and the default DT_W/MIN_ON constants, reusable by sine_pwm_simple benches.
- One natural sub-module: dt_counter (load/decrement/zero-flag, DT_W wide) for the dead-time timer. The FSM and on_cnt stay in the top.

Test Plan:
- Nominal switching: rst_n low 10 ns then high, en=1, dead_cycles=10, pwm_in square wave with 100-cycle period.
  - ls_out falls 2 cycles after each pwm_in rise; hs_out rises 12 cycles after it.
  - The mirror holds on falls.
  - hs_out & ls_out is never 1.
- Glitch filter: in LO_ON after 1 cycle, pwm_in pulses high for 2 cycles with MIN_ON=4.
  - No transition; ls_out stays 1.
  - A 6-cycle pulse is accepted.
- Reversal in dead time: pwm_in returns low while in DT_TO_HI with dead_cycles=10.
  - The DT state lasts exactly 10 cycles, then LO_ON.
  - hs_out never asserts.
- dead_cycles=0: each DT state lasts 1 cycle; the opposite output rises 3 cycles after the pwm_in edge.
- Fault: fault_n=0 during HI_ON.
  - Next cycle hs_out=0 and fault_latched=1.
  - fault_clr with fault_n still 0 is ignored.
  - fault_clr with fault_n=1 → IDLE, then DT → on-state.
- Enable/reset mid-operation: en=0 in DT_TO_LO gives IDLE with outputs 0 next cycle. rst_n asserted in HI_ON drops hs_out with no clock edge required.
